// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants for the instruction-memory loader.
// State encoding and widths shared with the instruction memory and the core's PC slice.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int INSTR_WIDTH        = 32;
  localparam int ADDR_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/imem_hold_timer.sv
// rtl/imem_hold_timer.sv - loadable down-counter with terminal-count flag.
// tc is high while enabled and the count has reached zero.
module imem_hold_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = enable && (count == '0);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams program words into instruction memory from word 0.
// Holds the core in reset while loading and for HOLD_CYCLES afterwards.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   in_valid,
  input  logic [INSTR_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH:0]    word_count
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  handshake;
  logic                  load_exit;
  logic                  start_clear;
  logic                  hold_tc;

  assign handshake   = in_valid && in_ready;
  assign load_exit   = handshake && (in_last || (ptr == LAST_ADDR));
  assign start_clear = load_start && ((state == IDLE) || (state == RUN));

  imem_hold_timer #(
    .WIDTH(8)
  ) u_hold_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load_exit),
    .load_value(8'(HOLD_CYCLES - 1)),
    .enable    (state == HOLD),
    .tc        (hold_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load_start) next_state = LOAD;
      LOAD:    if (load_exit)  next_state = HOLD;
      HOLD:    if (hold_tc)    next_state = RUN;
      RUN:     if (load_start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    case (state)
      LOAD: in_ready = 1'b1;
      RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  // Pointer stops at the last word; exit to HOLD covers the overflow case.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      word_count <= '0;
      error      <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_clear) begin
        ptr        <= '0;
        word_count <= '0;
        error      <= 1'b0;
      end else if (handshake) begin
        mem_we    <= 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= in_data;
        if (ptr != LAST_ADDR) begin
          ptr <= ptr + ADDR_WIDTH'(1);
        end
        if (word_count != FULL_COUNT) begin
          word_count <= word_count + (ADDR_WIDTH + 1)'(1);
        end
        if ((ptr == LAST_ADDR) && !in_last) begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader.
// A second instance with ADDR_WIDTH=2 exercises overflow and a full-depth program.
module tb_imem_loader;

  localparam int H = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load_start, in_valid, in_last;
  logic [31:0] in_data;
  logic        in_ready, mem_we, cpu_reset, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  logic        s_reset, s_load_start, s_in_valid, s_in_last;
  logic [31:0] s_in_data;
  logic        s_in_ready, s_mem_we, s_cpu_reset, s_done, s_error;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_word_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] prog [5] = '{32'h20010005, 32'h20020003, 32'h00221820, 32'hAC030000, 32'h08000004};

  imem_loader #(.ADDR_WIDTH(8), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .done(done), .error(error), .word_count(word_count)
  );

  imem_loader #(.ADDR_WIDTH(2), .HOLD_CYCLES(H)) dut_s (
    .clk(clk), .reset(s_reset), .load_start(s_load_start), .in_valid(s_in_valid),
    .in_data(s_in_data), .in_last(s_in_last), .in_ready(s_in_ready), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .cpu_reset(s_cpu_reset),
    .done(s_done), .error(s_error), .word_count(s_word_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; load_start = 0; in_valid = 0; in_last = 0; in_data = '0;
    s_reset = 1; s_load_start = 0; s_in_valid = 0; s_in_last = 0; s_in_data = '0;
    step(); step();

    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_word_count", word_count, 0);

    reset = 0; s_reset = 0;
    repeat (3) begin
      step();
      chk("idle_cpu_reset", cpu_reset, 1);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_mem_we", mem_we, 0);
      chk("idle_done", done, 0);
    end

    // Five-word program
    load_start = 1; step(); load_start = 0;
    chk("t1_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = prog[i]; in_last = (i == 4);
      step();
      chk("t1_mem_we", mem_we, 1);
      chk("t1_mem_addr", mem_addr, i);
      chk("t1_mem_wdata", mem_wdata, prog[i]);
    end
    in_valid = 0; in_last = 0;
    chk("t1_word_count", word_count, 5);
    chk("t1_hold_ready", in_ready, 0);
    chk("t1_hold_cpu_reset", cpu_reset, 1);
    for (int k = 1; k <= H; k++) begin
      step();
      chk("t1_release", cpu_reset, (k == H) ? 0 : 1);
    end
    chk("t1_done", done, 1);
    chk("t1_error", error, 0);

    // Alternate in_valid, three words; load_start in HOLD ignored
    load_start = 1; step(); load_start = 0;
    chk("t2_cpu_reset", cpu_reset, 1);
    chk("t2_done", done, 0);
    chk("t2_word_count0", word_count, 0);
    for (int j = 0; j < 5; j++) begin
      in_valid = (j % 2 == 0); in_data = 32'h100 + j; in_last = (j == 4);
      step();
      chk("t2_mem_we", mem_we, (j % 2 == 0));
      chk("t2_mem_addr", mem_addr, j / 2);
      chk("t2_mem_wdata", mem_wdata, 32'h100 + (j - j % 2));
    end
    in_valid = 0; in_last = 0;
    chk("t2_word_count", word_count, 3);
    for (int k = 1; k <= H; k++) begin
      load_start = (k == 1);
      step();
      load_start = 0;
      chk("t2_release", cpu_reset, (k == H) ? 0 : 1);
    end
    chk("t2_done", done, 1);
    chk("t2_word_count_run", word_count, 3);

    // Reload from RUN with one word; load_start in LOAD ignored
    load_start = 1; step();
    chk("t3_cpu_reset", cpu_reset, 1);
    chk("t3_in_ready", in_ready, 1);
    step();
    chk("t3_still_load", in_ready, 1);
    load_start = 0;
    in_valid = 1; in_data = 32'hDEADBEEF; in_last = 1;
    step();
    in_valid = 0; in_last = 0;
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_addr", mem_addr, 0);
    chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t3_word_count", word_count, 1);
    for (int k = 1; k <= H; k++) begin
      step();
      chk("t3_done", done, (k == H) ? 1 : 0);
    end

    // Reset after two of four words
    load_start = 1; step(); load_start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = 32'h55000000 + i; in_last = 0;
      step();
      chk("t4_mem_addr", mem_addr, i);
    end
    in_data = 32'h55000002;
    reset = 1; step();
    chk("t4_in_ready", in_ready, 0);
    chk("t4_cpu_reset", cpu_reset, 1);
    chk("t4_mem_we", mem_we, 0);
    chk("t4_error", error, 0);
    chk("t4_word_count", word_count, 0);
    chk("t4_done", done, 0);
    reset = 0; in_valid = 0;
    step();
    chk("t4_idle_ready", in_ready, 0);
    load_start = 1; step(); load_start = 0;
    in_valid = 1; in_data = 32'h77; in_last = 1;
    step();
    in_valid = 0; in_last = 0;
    chk("t4_reload_we", mem_we, 1);
    chk("t4_reload_addr", mem_addr, 0);
    chk("t4_reload_data", mem_wdata, 32'h77);
    chk("t4_reload_count", word_count, 1);

    // Overflow on the four-word instance
    s_load_start = 1; step(); s_load_start = 0;
    for (int i = 0; i < 6; i++) begin
      s_in_valid = 1; s_in_data = 32'hA0 + i; s_in_last = 0;
      chk("t5_in_ready", s_in_ready, (i < 4));
      step();
      chk("t5_mem_we", s_mem_we, (i < 4));
      if (i < 4) chk("t5_mem_addr", s_mem_addr, i);
      if (i == 3) begin
        chk("t5_error", s_error, 1);
        chk("t5_word_count", s_word_count, 4);
      end
    end
    s_in_valid = 0;
    repeat (H - 2) step();
    chk("t5_done", s_done, 1);
    chk("t5_error_sticky", s_error, 1);
    chk("t5_count_sat", s_word_count, 4);

    // Full-depth legal program: last word at address DEPTH-1
    s_load_start = 1; step(); s_load_start = 0;
    chk("t6_error_clear", s_error, 0);
    chk("t6_count_clear", s_word_count, 0);
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1; s_in_data = 32'hB0 + i; s_in_last = (i == 3);
      step();
      chk("t6_mem_addr", s_mem_addr, i);
      chk("t6_mem_wdata", s_mem_wdata, 32'hB0 + i);
    end
    s_in_valid = 0; s_in_last = 0;
    chk("t6_error", s_error, 0);
    chk("t6_word_count", s_word_count, 4);
    chk("t6_in_ready", s_in_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
